// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Optional build macro DIV_EARLY_EXIT_EN: a zero divisor skips the iterations and completes on the accept edge.
module seq_divider #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero
);

    localparam int DW = 2 * W;
    localparam int CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [DW-1:0] dividend_reg;
    logic [W-1:0]  divisor_reg;
    logic [W-1:0]  part_reg;
    logic [DW-2:0] quo_reg;
    logic [CW-1:0] cnt_reg;
    logic [DW-1:0] quotient_reg;
    logic [W-1:0]  remainder_reg;
    logic          div_zero_reg;

    logic [CW-1:0] bit_idx;
    logic [W:0]    shifted;
    logic [W-1:0]  diff;
    logic          borrow;
    logic [W-1:0]  part_next;
    logic [DW-1:0] quo_next;
    logic          last_iter;
    logic          accept;
    logic          zero_in;
    logic          zero_held;

    // One restoring step: bring down the next dividend bit (MSB first), trial-subtract.
    assign bit_idx   = LAST - cnt_reg;
    assign shifted   = {part_reg, dividend_reg[bit_idx]};
    assign borrow    = shifted < {1'b0, divisor_reg};
    // The kept difference is always below the divisor, so W bits are enough.
    assign diff      = shifted[W-1:0] - divisor_reg;
    assign part_next = borrow ? shifted[W-1:0] : diff;
    assign quo_next  = {quo_reg, ~borrow};

    assign last_iter = (cnt_reg == LAST);
    assign accept    = in_valid && (state_reg == IDLE);
    assign zero_in   = (divisor == '0);
    assign zero_held = (divisor_reg == '0);

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
`ifdef DIV_EARLY_EXIT_EN
                    state_next = zero_in ? DONE : BUSY;
`else
                    state_next = BUSY;
`endif
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            part_reg      <= '0;
            quo_reg       <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dividend_reg <= dividend;
                        divisor_reg  <= divisor;
                        part_reg     <= '0;
                        quo_reg      <= '0;
                        cnt_reg      <= '0;
`ifdef DIV_EARLY_EXIT_EN
                        if (zero_in) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend[W-1:0];
                            div_zero_reg  <= 1'b1;
                        end
`else
                        if (zero_in) begin
                            div_zero_reg <= 1'b0;
                        end
`endif
                    end
                end
                BUSY: begin
                    part_reg <= part_next;
                    quo_reg  <= quo_next[DW-2:0];
                    if (!last_iter) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (zero_held) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dividend_reg[W-1:0];
                        div_zero_reg  <= 1'b1;
                    end else begin
                        quotient_reg  <= quo_next;
                        remainder_reg <= part_next;
                        div_zero_reg  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (W=3): results, latency, output hold, reset abort, back-to-back.
module tb_seq_divider;

    localparam int W = 3;
`ifdef DIV_EARLY_EXIT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 7;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a negedge with out_ready already set; leaves the bench at the
    // negedge where out_valid was first seen (or one later, once consumed when out_ready=1).
    task automatic run_op(input string tag, input int a, input int b,
                          input int exp_q, input int exp_r, input int exp_dz, input int exp_lat);
        int c;
        bit seen;
        check_val({tag, " in_ready"}, int'(in_ready), 1);
        dividend = (2*W)'(a);
        divisor  = W'(b);
        in_valid = 1'b1;
        c = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            c++;
            if (out_valid) seen = 1'b1;
        end
        check_val({tag, " out_valid seen"}, int'(seen), 1);
        check_val({tag, " latency"}, c, exp_lat);
        check_val({tag, " quotient"}, int'(quotient), exp_q);
        check_val({tag, " remainder"}, int'(remainder), exp_r);
        check_val({tag, " div_zero"}, int'(div_zero), exp_dz);
        $display("%s: %0d / %0d -> q=%0d r=%0d dz=%0d after %0d cycles",
                 tag, a, b, quotient, remainder, div_zero, c);
        if (out_ready) begin
            @(negedge clk);
            check_val({tag, " consumed out_valid"}, int'(out_valid), 0);
            check_val({tag, " consumed in_ready"}, int'(in_ready), 1);
        end
    endtask

    initial begin
        int c;
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("reset in_ready", int'(in_ready), 1);
        check_val("reset out_valid", int'(out_valid), 0);
        check_val("reset quotient", int'(quotient), 0);
        check_val("reset remainder", int'(remainder), 0);
        check_val("reset div_zero", int'(div_zero), 0);
        $display("reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);

        // T1 / T2 / T3
        run_op("t1 42/5", 42, 5, 8, 2, 0, 7);
        run_op("t2 63/1", 63, 1, 63, 0, 0, 7);
        run_op("t2 63/7", 63, 7, 9, 0, 0, 7);
        run_op("t2 5/7", 5, 7, 0, 5, 0, 7);
        run_op("t3 45/0", 45, 0, 63, 5, 1, ZLAT);
        run_op("t2 0/3", 0, 3, 0, 0, 0, 7);

        // T4: hold result with out_ready low, try to push a new operation meanwhile
        out_ready = 1'b0;
        run_op("t4 42/5", 42, 5, 8, 2, 0, 7);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                dividend = 6'd17;
                divisor  = 3'd4;
                in_valid = 1'b1;
            end
            @(negedge clk);
            check_val("t4 hold out_valid", int'(out_valid), 1);
            check_val("t4 hold in_ready", int'(in_ready), 0);
            check_val("t4 hold quotient", int'(quotient), 8);
            check_val("t4 hold remainder", int'(remainder), 2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("t4 release out_valid", int'(out_valid), 0);
        check_val("t4 release in_ready", int'(in_ready), 1);
        $display("t4: held 5 cycles, released, in_ready=%0d", in_ready);

        // T5: reset during BUSY
        dividend = 6'd42;
        divisor  = 3'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t5 rst in_ready", int'(in_ready), 1);
        check_val("t5 rst out_valid", int'(out_valid), 0);
        check_val("t5 rst quotient", int'(quotient), 0);
        check_val("t5 rst remainder", int'(remainder), 0);
        check_val("t5 rst div_zero", int'(div_zero), 0);
        $display("t5: aborted 42/5 at cycle 3");
        run_op("t5 20/3", 20, 3, 6, 2, 0, 7);

        // T6: in_valid held high across two operations
        dividend = 6'd42;
        divisor  = 3'd5;
        in_valid = 1'b1;
        @(negedge clk);
        dividend = 6'd17;
        divisor  = 3'd4;
        c = 1;
        check_val("t6 busy in_ready", int'(in_ready), 0);
        seen = out_valid;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            c++;
            if (out_valid) seen = 1'b1;
        end
        check_val("t6 first seen", int'(seen), 1);
        check_val("t6 first latency", c, 7);
        check_val("t6 first quotient", int'(quotient), 8);
        check_val("t6 first remainder", int'(remainder), 2);
        $display("t6: first 42/5 -> q=%0d r=%0d", quotient, remainder);
        @(negedge clk);
        check_val("t6 second accept in_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("t6 second busy in_ready", int'(in_ready), 0);
        c = 1;
        seen = out_valid;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            c++;
            if (out_valid) seen = 1'b1;
        end
        check_val("t6 second seen", int'(seen), 1);
        check_val("t6 second latency", c, 7);
        check_val("t6 second quotient", int'(quotient), 4);
        check_val("t6 second remainder", int'(remainder), 1);
        $display("t6: second 17/4 -> q=%0d r=%0d", quotient, remainder);
        @(negedge clk);
        check_val("t6 drained out_valid", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
